nbit_acc_shift_reg: RTL
=======================

# nbit_acc_shift_reg

Parametrised N-bit accumulator register with a sequential shift/rotate/count unit, replacing the fixed load/store-only register on the accumulator datapath. Besides load, synchronous set and clear, it runs multi-cycle serial shifts and rotates (one bit per clock), single-step increment/decrement, and rotate-through-carry. A carry flag, a zero flag and a busy/done handshake connect it to the control unit.

## Interface
- N, 8, register width (≥2)
- AW, 3, width of shift-amount port; amounts 0..2^AW-1

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- ld_str  in  1  load `in` into register (idle only)
- set  in  1  synchronous set: register to all ones (idle only)
- clr  in  1  synchronous clear: register and carry to 0; aborts any operation
- start  in  1  begin operation `op` (idle only)
- op  in  3  operation code, sampled with start
- amt  in  AW  shift/rotate count, sampled with start
- in  in  N  load data
- out  out  N  register contents
- cout  out  1  carry flag (registered)
- zero  out  1  combinational, out == 0
- busy  out  1  high while an operation is in progress (state RUN)
- done  out  1  one-cycle pulse: operation complete

## Operation
- op codes: 000 SHL (fill 0), 001 SHR (fill 0), 010 SAR (fill MSB), 011 ROL, 100 ROR, 101 INC, 110 DEC, 111 RLC (rotate left through cout).
- Per-step cout: the bit shifted or rotated out (SHL/ROL/RLC: old MSB; SHR/SAR/ROR: old LSB). INC: carry out of MSB. DEC: borrow (1 when old value was 0).
- RLC step: out <= {out[N-2:0], cout}, cout <= old out[N-1].
- INC/DEC ignore amt and always take exactly one step.
- States: IDLE, RUN. The step counter is AW bits wide.
- IDLE priority per edge: clr > set > start > ld_str > hold.
  - start with step count 0 (a shift op with amt=0): stay in IDLE, pulse done, out and cout unchanged.
  - start otherwise: go to RUN, counter <= step count.
- RUN, per edge:
  - If clr: out=0, cout=0, go to IDLE, no done pulse.
  - Else perform one step and decrement the counter. When the counter was 1, go to IDLE and pulse done.
  - set, start and ld_str are ignored in RUN.
- ld_str and set never change cout.
- rst (asynchronous): out=0, cout=0, state IDLE, counter=0, done=0. Release is synchronous to the next edge. Reset during RUN abandons the operation with no done pulse.

## Timing
- Reset values: out=0, cout=0, busy=0, done=0, zero=1.
- ld_str, set and clr take effect at the next edge. Results are visible in the following cycle.
- Start accepted at edge k with step count S≥1:
  - busy=1 in the cycles after edges k..k+S-1.
  - Steps occur at edges k+1..k+S.
  - done=1 for one cycle after edge k+S, with the final out and cout valid in that same cycle. busy=0 in that cycle.
  - A new start is accepted at edge k+S+1 at the earliest (busy=0 by then).
- Start with S=0 at edge k: done=1 for the cycle after edge k. busy never rises.
- Total latency from start to done is S+1 edges. Back-to-back throughput is one operation per S+1 cycles.
- done is registered and never high for two consecutive cycles from a single start.

## Test plan
- Reset: assert rst mid-cycle with out=0x5A → immediately out=0x00, cout=0, busy=0, done=0, zero=1.
- Load 0x96, start SHL amt=3 → busy for 3 cycles, then out=0xB0, cout=0 with done pulse. After step 1, cout=1.
- Load 0x90, start SAR amt=2 → out=0xE4, cout=0. Then start ROR amt=1 → out=0x72, cout=0.
- Load 0x81 with cout=0, start RLC amt=1 → out=0x02, cout=1. Repeat → out=0x05, cout=0.
- Load 0xFF, start INC → after 1 step out=0x00, cout=1, zero=1, done pulse. Then start DEC → out=0xFF, cout=1.
- Abort and ignore cases:
  - Load 0xFF, start SHR amt=7, pulse start and ld_str=0x11 during busy → both ignored.
  - Assert clr in the 3rd RUN cycle → out=0x00, cout=0, busy=0 next cycle, no done.
  - Separately, start SHL amt=0 → done next cycle, out unchanged, busy stays 0.

Source files
------------

// File: rtl/nbit_acc_shift_reg.sv
// N-bit accumulator register with serial shift/rotate/count unit.
// Operations take one step per clock; busy/done handshake to the control unit.
module nbit_acc_shift_reg #(
  parameter int N  = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_str,
  input  logic          set,
  input  logic          clr,
  input  logic          start,
  input  logic [2:0]    op,
  input  logic [AW-1:0] amt,
  input  logic [N-1:0]  in,
  output logic [N-1:0]  out,
  output logic          cout,
  output logic          zero,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    OP_SHL = 3'b000,
    OP_SHR = 3'b001,
    OP_SAR = 3'b010,
    OP_ROL = 3'b011,
    OP_ROR = 3'b100,
    OP_INC = 3'b101,
    OP_DEC = 3'b110,
    OP_RLC = 3'b111
  } op_e;

  typedef enum logic {IDLE, RUN} state_e;

  state_e        state_q, state_d;
  op_e           op_q, op_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  out_q, out_d;
  logic          cout_q, cout_d;
  logic          done_q, done_d;

  op_e           op_in;
  logic [AW-1:0] start_cnt;
  logic [N-1:0]  step_val;
  logic          step_cout;

  assign op_in     = op_e'(op);
  assign start_cnt = (op_in == OP_INC || op_in == OP_DEC) ? AW'(1) : amt;

  // One step of the latched operation applied to the current register.
  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    step_val  = out_q;
    step_cout = cout_q;
    unique case (op_q)
      OP_SHL: begin step_val = {out_q[N-2:0], 1'b0};        step_cout = out_q[N-1]; end
      OP_SHR: begin step_val = {1'b0, out_q[N-1:1]};        step_cout = out_q[0];   end
      OP_SAR: begin step_val = {out_q[N-1], out_q[N-1:1]};  step_cout = out_q[0];   end
      OP_ROL: begin step_val = {out_q[N-2:0], out_q[N-1]};  step_cout = out_q[N-1]; end
      OP_ROR: begin step_val = {out_q[0], out_q[N-1:1]};    step_cout = out_q[0];   end
      OP_INC: {step_cout, step_val} = {1'b0, out_q} + (N+1)'(1);
      OP_DEC: begin step_val = out_q - N'(1);               step_cout = (out_q == '0); end
      OP_RLC: begin step_val = {out_q[N-2:0], cout_q};      step_cout = out_q[N-1]; end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    cout_d  = cout_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clr) begin
          out_d  = '0;
          cout_d = 1'b0;
        end else if (set) begin
          out_d = '1;
        end else if (start) begin
          op_d = op_in;
          if (start_cnt == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = RUN;
            cnt_d   = start_cnt;
          end
        end else if (ld_str) begin
          out_d = in;
        end
      end
      RUN: begin
        if (clr) begin
          out_d   = '0;
          cout_d  = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          out_d  = step_val;
          cout_d = step_cout;
          cnt_d  = cnt_q - AW'(1);
          if (cnt_q == AW'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_SHL;
      cnt_q   <= '0;
      out_q   <= '0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
    end
  end

  assign out  = out_q;
  assign cout = cout_q;
  assign zero = (out_q == '0);
  assign busy = (state_q == RUN);
  assign done = done_q;

endmodule
